// File: rtl/divider_seq_if.sv
// Handshake and operand/result bundle for the sequential divider.
// master: issues start with operands and receives results.
// slave: the divider; accepts start only while ready, pulses done with results.
interface divider_seq_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         ready;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  ready, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done rises on the Nth edge after the accepted start; on the accept edge itself for a zero divisor.
// Backpressure: start is honoured only while ready; starts during RUN/DONE are dropped, never queued.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carries
//   start/dividend/divisor in and ready/done/quotient/remainder/div_by_zero out.
module divider_seq #(
   parameter int N = 8
) (
   input logic          clk,
   input logic          rst,
   divider_seq_if.slave bus
);
   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N:0]    r_q,     r_d;     // partial remainder (N+1 bits)
   logic [N-1:0]  q_q,     q_d;     // dividend shifting out / quotient shifting in
   logic [N-1:0]  d_q,     d_d;     // captured divisor
   logic [CW-1:0] cnt_q,   cnt_d;   // iterations remaining
   logic [N-1:0]  quot_q,  quot_d;  // result registers, separate from the working Q/R
   logic [N-1:0]  rem_q,   rem_d;
   logic          dbz_q,   dbz_d;

   // One restoring step. R < D always holds between steps, so the shifted
   // value fits in N+1 bits; the extra top bit of the difference is the borrow.
   logic [N+1:0]  shifted;
   logic [N+1:0]  diff;
   logic          borrow;
   logic [N:0]    r_next;
   logic [N-1:0]  q_next;

   always_comb begin
      shifted = {r_q, q_q[N-1]};
      diff    = shifted - {2'b00, d_q};
      borrow  = diff[N+1];
      r_next  = borrow ? shifted[N:0] : diff[N:0];
      q_next  = {q_q[N-2:0], ~borrow};
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.divisor != '0) begin
                  r_d     = '0;
                  q_d     = bus.dividend;
                  d_d     = bus.divisor;
                  cnt_d   = CW'(N);
                  dbz_d   = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  // Zero divisor short-circuits straight to DONE.
                  quot_d  = '1;
                  rem_d   = bus.dividend;
                  dbz_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quot_d  = q_next;
               rem_d   = r_next[N-1:0];
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.ready       = (state_q == ST_IDLE);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed operands, busy-start, mid-run reset and
// random operands, all checked against plain '/' and '%' arithmetic.
module tb_divider_seq;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   divider_seq_if #(.N(N)) bus ();

   divider_seq #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp    = 0;
   int n_err    = 0;
   int done_cnt = 0;
   int accepted = 0;
   logic [N-1:0] last_q = '0;
   logic [N-1:0] last_r = '0;

   // Every cycle with done high is one completion pulse.
   always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, 32'(bus.ready), 32'd1);
      check({tag, "_done"},  32'(bus.done), 32'd0);
      check({tag, "_quot"},  32'(bus.quotient), 32'd0);
      check({tag, "_rem"},   32'(bus.remainder), 32'd0);
      check({tag, "_dbz"},   32'(bus.div_by_zero), 32'd0);
   endtask

   // Reference: ordinary integer division; a zero divisor yields all-ones / dividend.
   // edges_to_done counts clock edges after the accepting edge until done is seen.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] eq, er;
      logic         edz;
      int           exp_edges, edges;
      if (b == '0) begin
         eq = '1; er = a; edz = 1'b1; exp_edges = 0;
      end else begin
         eq = a / b; er = a % b; edz = 1'b0; exp_edges = N;
      end
      check("ready_before_start", 32'(bus.ready), 32'd1);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      step();
      accepted++;
      bus.start    = 1'b0;
      bus.dividend = N'($urandom);
      bus.divisor  = N'($urandom);
      edges = 0;
      while (bus.done !== 1'b1 && edges < N + 4) begin
         step();
         edges++;
      end
      check("edges_to_done", 32'(edges), 32'(exp_edges));
      check("quotient", 32'(bus.quotient), 32'(eq));
      check("remainder", 32'(bus.remainder), 32'(er));
      check("div_by_zero", 32'(bus.div_by_zero), 32'(edz));
      step();
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("ready_after_done", 32'(bus.ready), 32'd1);
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      int edges;
      int done_snap;
      logic [N-1:0] ra, rb;

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) step();
      check_reset_values("reset");
      rst = 1'b0;
      step();

      // Basic and boundary operands
      run_op(8'd100, 8'd7);
      run_op(8'd255, 8'd1);
      run_op(8'd5,   8'd10);
      run_op(8'd255, 8'd255);
      run_op(8'd0,   8'd3);
      run_op(8'd200, 8'd0);
      run_op(8'd9,   8'd3);

      // A start while busy is dropped; previous results hold through RUN.
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      step();
      accepted++;
      bus.start = 1'b0;
      edges = 0;
      while (bus.done !== 1'b1 && edges < N + 4) begin
         if (edges == 2) begin
            bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
         end
         step();
         edges++;
         bus.start = 1'b0;
         if (bus.done !== 1'b1) begin
            check("hold_quot_in_run", 32'(bus.quotient), 32'(last_q));
            check("hold_rem_in_run", 32'(bus.remainder), 32'(last_r));
         end
      end
      check("busy_edges_to_done", 32'(edges), 32'(N));
      check("busy_quotient", 32'(bus.quotient), 32'd14);
      check("busy_remainder", 32'(bus.remainder), 32'd2);
      step();
      check("busy_ready_after", 32'(bus.ready), 32'd1);
      last_q = 8'd14; last_r = 8'd2;

      // Reset in the middle of RUN discards the operation without a done pulse.
      done_snap = done_cnt;
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_values("midrun_reset");
      repeat (N + 2) step();
      check("no_done_after_reset", 32'(done_cnt), 32'(done_snap));
      run_op(8'd17, 8'd4);

      // Random operands, zero divisor roughly one time in sixteen.
      for (int i = 0; i < 1000; i++) begin
         ra = N'($urandom);
         rb = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
         run_op(ra, rb);
      end

      check("done_per_accepted_start", 32'(done_cnt), 32'(accepted));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
